// File: rtl/temporal_pingpong_buffer.sv
// rtl/temporal_pingpong_buffer.sv - double-banked literal-set store between clause fetch and flip selector
module temporal_pingpong_buffer #(
    parameter int NSAT                  = 3,
    parameter int LITERAL_ADDRESS_WIDTH = 12,
    parameter int MAX_CLAUSE_MEMBERSHIP = 20,
    localparam int EW = (NSAT - 1) * MAX_CLAUSE_MEMBERSHIP * (LITERAL_ADDRESS_WIDTH + 1),
    localparam int IW = (NSAT > 1) ? $clog2(NSAT) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          wr_en_i,
    input  logic [IW-1:0] wr_index_i,
    input  logic [EW-1:0] wr_literals_i,
    input  logic          wr_commit_i,
    output logic          wr_ready_o,
    output logic          rd_valid_o,
    input  logic          rd_req_i,
    input  logic [IW-1:0] rd_index_i,
    output logic [EW-1:0] rd_literals_o,
    output logic          rd_data_valid_o,
    output logic          rd_slot_hit_o,
    input  logic          rd_release_i,
    output logic [1:0]    occupancy_o
);

    localparam logic [IW:0] NSAT_W = (IW + 1)'(NSAT);

    logic [EW-1:0]   entry_q [2][NSAT];
    logic [EW-1:0]   entry_d [2][NSAT];
    logic [NSAT-1:0] slot_valid_q [2];
    logic [NSAT-1:0] slot_valid_d [2];
    logic            fb_q, fb_d;
    logic            rb_q, rb_d;
    logic [1:0]      bank_full_q, bank_full_d;
    logic [EW-1:0]   rd_literals_q, rd_literals_d;
    logic            rd_data_valid_q, rd_data_valid_d;
    logic            rd_slot_hit_q, rd_slot_hit_d;

    logic            wr_idx_ok, rd_idx_ok;
    logic [IW-1:0]   wr_slot, rd_slot;
    logic            wr_fire, commit_fire, read_fire, release_fire;

    assign wr_ready_o      = !bank_full_q[fb_q];
    assign rd_valid_o      = bank_full_q[rb_q];
    assign occupancy_o     = {1'b0, bank_full_q[0]} + {1'b0, bank_full_q[1]};
    assign rd_literals_o   = rd_literals_q;
    assign rd_data_valid_o = rd_data_valid_q;
    assign rd_slot_hit_o   = rd_slot_hit_q;

    // Out-of-range indices are folded to slot 0 so array selects stay in bounds; the *_idx_ok terms gate their effect.
    assign wr_idx_ok    = {1'b0, wr_index_i} < NSAT_W;
    assign rd_idx_ok    = {1'b0, rd_index_i} < NSAT_W;
    assign wr_slot      = wr_idx_ok ? wr_index_i : '0;
    assign rd_slot      = rd_idx_ok ? rd_index_i : '0;
    assign wr_fire      = wr_en_i && wr_ready_o && wr_idx_ok;
    assign commit_fire  = wr_commit_i && wr_ready_o;
    assign read_fire    = rd_req_i && rd_valid_o;
    assign release_fire = rd_release_i && rd_valid_o;

    always_comb begin
        entry_d         = entry_q;
        slot_valid_d    = slot_valid_q;
        fb_d            = fb_q;
        rb_d            = rb_q;
        bank_full_d     = bank_full_q;
        rd_literals_d   = rd_literals_q;
        rd_data_valid_d = 1'b0;
        rd_slot_hit_d   = 1'b0;

        if (wr_fire) begin
            entry_d[fb_q][wr_slot]      = wr_literals_i;
            slot_valid_d[fb_q][wr_slot] = 1'b1;
        end

        if (commit_fire) begin
            bank_full_d[fb_q] = 1'b1;
            fb_d              = !fb_q;
        end

        // Reads sample the pre-release bank contents, so a same-cycle release is harmless.
        if (read_fire) begin
            rd_data_valid_d = 1'b1;
            rd_slot_hit_d   = rd_idx_ok && slot_valid_q[rb_q][rd_slot];
            rd_literals_d   = rd_slot_hit_d ? entry_q[rb_q][rd_slot] : '0;
        end

        // Release never targets the fill bank: a full read bank and a free fill bank are distinct.
        if (release_fire) begin
            bank_full_d[rb_q]  = 1'b0;
            slot_valid_d[rb_q] = '0;
            rb_d               = !rb_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            slot_valid_q[0] <= '0;
            slot_valid_q[1] <= '0;
            fb_q            <= 1'b0;
            rb_q            <= 1'b0;
            bank_full_q     <= '0;
            rd_literals_q   <= '0;
            rd_data_valid_q <= 1'b0;
            rd_slot_hit_q   <= 1'b0;
        end else begin
            slot_valid_q    <= slot_valid_d;
            fb_q            <= fb_d;
            rb_q            <= rb_d;
            bank_full_q     <= bank_full_d;
            rd_literals_q   <= rd_literals_d;
            rd_data_valid_q <= rd_data_valid_d;
            rd_slot_hit_q   <= rd_slot_hit_d;
        end
    end

    // Entry payload is never reset; stale data is masked by slot_valid.
    always_ff @(posedge clk_i) begin
        entry_q <= entry_d;
    end

endmodule

// File: tb/tb_temporal_pingpong_buffer.sv
// tb/tb_temporal_pingpong_buffer.sv - randomized bench against a round-queue reference model
module tb_temporal_pingpong_buffer;

    localparam int NSAT = 3;
    localparam int EW   = (NSAT - 1) * 20 * 13;
    localparam int IW   = 2;

    logic          clk = 1'b0;
    logic          rst_i, flush_i;
    logic          wr_en_i, wr_commit_i, rd_req_i, rd_release_i;
    logic [IW-1:0] wr_index_i, rd_index_i;
    logic [EW-1:0] wr_literals_i;
    logic          wr_ready_o, rd_valid_o, rd_data_valid_o, rd_slot_hit_o;
    logic [EW-1:0] rd_literals_o;
    logic [1:0]    occupancy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    temporal_pingpong_buffer dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .wr_en_i(wr_en_i), .wr_index_i(wr_index_i), .wr_literals_i(wr_literals_i),
        .wr_commit_i(wr_commit_i), .wr_ready_o(wr_ready_o), .rd_valid_o(rd_valid_o),
        .rd_req_i(rd_req_i), .rd_index_i(rd_index_i), .rd_literals_o(rd_literals_o),
        .rd_data_valid_o(rd_data_valid_o), .rd_slot_hit_o(rd_slot_hit_o),
        .rd_release_i(rd_release_i), .occupancy_o(occupancy_o)
    );

    // A round is a complete literal-set collection; committed rounds wait in FIFO order.
    typedef struct packed {
        logic [NSAT-1:0]         v;
        logic [NSAT-1:0][EW-1:0] d;
    } round_t;

    round_t        committed[$];
    round_t        filling;
    logic          exp_dv, exp_hit;
    logic [EW-1:0] exp_lit;
    logic [EW-1:0] pat [8];

    task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] rand_lit();
        logic [EW-1:0] r = '0;
        for (int i = 0; i < (EW + 31) / 32; i++) r = (r << 32) | EW'($urandom);
        return r;
    endfunction

    task automatic model_step();
        bit ready, valid;
        if (rst_i || flush_i) begin
            committed.delete();
            filling = '0;
            exp_dv  = 1'b0;
            exp_hit = 1'b0;
            exp_lit = '0;
            return;
        end
        ready  = committed.size() < 2;
        valid  = committed.size() > 0;
        exp_dv = rd_req_i && valid;
        exp_hit = 1'b0;
        if (exp_dv) begin
            exp_hit = (int'(rd_index_i) < NSAT) && committed[0].v[rd_index_i];
            exp_lit = exp_hit ? committed[0].d[rd_index_i] : '0;
        end
        if (wr_en_i && ready && int'(wr_index_i) < NSAT) begin
            filling.d[wr_index_i] = wr_literals_i;
            filling.v[wr_index_i] = 1'b1;
        end
        if (rd_release_i && valid) void'(committed.pop_front());
        if (wr_commit_i && ready) begin
            committed.push_back(filling);
            filling = '0;
        end
    endtask

    task automatic idle();
        rst_i = 0; flush_i = 0; wr_en_i = 0; wr_commit_i = 0;
        rd_req_i = 0; rd_release_i = 0; wr_index_i = '0; rd_index_i = '0;
        wr_literals_i = '0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("wr_ready", EW'(wr_ready_o), EW'(committed.size() < 2));
        check("rd_valid", EW'(rd_valid_o), EW'(committed.size() > 0));
        check("occupancy", EW'(occupancy_o), EW'(committed.size()));
        check("rd_data_valid", EW'(rd_data_valid_o), EW'(exp_dv));
        if (exp_dv) begin
            check("rd_slot_hit", EW'(rd_slot_hit_o), EW'(exp_hit));
            check("rd_literals", rd_literals_o, exp_lit);
        end
        idle();
    endtask

    task automatic wr(input int idx, input logic [EW-1:0] lit, input bit commit);
        wr_en_i = 1; wr_index_i = IW'(idx); wr_literals_i = lit; wr_commit_i = commit;
        tick();
    endtask

    task automatic rd(input int idx, input bit rel);
        rd_req_i = 1; rd_index_i = IW'(idx); rd_release_i = rel;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) pat[i] = rand_lit();
        idle();
        rst_i = 1;
        tick();
        check("reset_literals", rd_literals_o, '0);
        check("reset_hit", EW'(rd_slot_hit_o), '0);
        check("reset_ready", EW'(wr_ready_o), EW'(1));

        // Fill A,B,C and read slot 1
        wr(0, pat[0], 0); wr(1, pat[1], 0); wr(2, pat[2], 0);
        wr_commit_i = 1; tick();
        check("commit_occ", EW'(occupancy_o), EW'(1));
        rd(1, 0);
        tick();
        // Second round D,E,F, then a dropped write G
        wr(0, pat[3], 0); wr(1, pat[4], 0); wr(2, pat[5], 1);
        check("full_not_ready", EW'(wr_ready_o), EW'(0));
        wr(0, pat[6], 0);
        rd_release_i = 1; tick();
        check("ready_after_release", EW'(wr_ready_o), EW'(1));
        rd(0, 0);
        // Partial round: slot 2 only
        wr(2, pat[7], 1);
        rd(0, 1);
        rd(0, 0); rd(2, 0);
        // Write with commit, then read with release
        wr(1, pat[0], 1);
        rd(1, 1);
        rd(1, 1);
        // Out-of-range indices and ignored control
        wr(3, pat[1], 0);
        wr_commit_i = 1; tick();
        rd(3, 0); rd(0, 1);
        rd(0, 1); rd_release_i = 1; tick();
        // Flush during a read
        wr(0, pat[2], 1);
        rd_req_i = 1; flush_i = 1; tick();
        check("flush_dv", EW'(rd_data_valid_o), '0);
        wr_commit_i = 1; tick();
        rd(0, 0); rd(1, 0); rd(2, 1);

        for (int n = 0; n < 3000; n++) begin
            rst_i         = ($urandom_range(0, 199) == 0);
            flush_i       = ($urandom_range(0, 99) == 0);
            wr_en_i       = $urandom_range(0, 1);
            wr_index_i    = IW'($urandom_range(0, 3));
            wr_literals_i = rand_lit();
            wr_commit_i   = ($urandom_range(0, 5) == 0);
            rd_req_i      = $urandom_range(0, 1);
            rd_index_i    = IW'($urandom_range(0, 3));
            rd_release_i  = ($urandom_range(0, 5) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
